// File: rtl/writeback_reorder_unit_pkg.sv
// Shared types for writeback_reorder_unit: per-slot writeback payload, reorder entry and pipeline result port.
// The struct field widths follow WB_WIDTH / WB_DEPTH, which are the top-level parameter defaults.
package writeback_reorder_unit_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_DEPTH = 4;
    localparam int WB_TAG_W = $clog2(WB_DEPTH);

    typedef struct packed {
        logic [4:0]          rd;
        logic                we;
        logic [WB_WIDTH-1:0] data;
    } wb_slot_t;

    typedef struct packed {
        logic           valid;
        logic [1:0]     mask;
        logic [1:0]     done;
        wb_slot_t [1:0] slot;
    } rob_entry_t;

    typedef struct packed {
        logic                valid;
        logic [WB_TAG_W-1:0] tag;
        logic                slot;
        logic [4:0]          rd;
        logic                we;
        logic [WB_WIDTH-1:0] data;
    } wb_result_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/writeback_reorder_unit_wb_conflict_resolve.sv
// Final register-file write enables for a retiring bundle; on a same-register
// collision the younger slot (slot 1) keeps its write.
module wb_conflict_resolve (
    input  logic [1:0] mask_i,
    input  logic [1:0] we_i,
    input  logic [4:0] rd0_i,
    input  logic [4:0] rd1_i,
    output logic [1:0] we_o
);

    logic w0;
    logic w1;

    assign w0 = mask_i[0] && we_i[0] && (rd0_i != 5'd0);
    assign w1 = mask_i[1] && we_i[1] && (rd1_i != 5'd0);

    assign we_o[1] = w1;
    assign we_o[0] = w0 && !(w1 && (rd0_i == rd1_i));

endmodule

// File: rtl/writeback_reorder_unit.sv
// In-order writeback reorder buffer for dual-issue bundles fed by the Branch and Memory pipelines.
// Optional: define RETIRE_COUNT_EN to add the 64-bit retire_count output.
module writeback_reorder_unit
    import writeback_reorder_unit_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int DEPTH = WB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [1:0]       alloc_mask,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             br_valid,
    input  logic [TAG_W-1:0] br_tag,
    input  logic             br_slot,
    input  logic [4:0]       br_rd,
    input  logic             br_we,
    input  logic [WIDTH-1:0] br_data,
    input  logic             mem_valid,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic             mem_slot,
    input  logic [4:0]       mem_rd,
    input  logic             mem_we,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             flush,
    output logic             wb_we_0,
    output logic             wb_we_1,
    output logic [4:0]       wb_rd_0,
    output logic [4:0]       wb_rd_1,
    output logic [WIDTH-1:0] wb_data_0,
    output logic [WIDTH-1:0] wb_data_1,
    output logic             retire_pulse,
    output logic             err
`ifdef RETIRE_COUNT_EN
    ,
    output logic [63:0]      retire_count
`endif
);

    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    rob_entry_t       rob_q [DEPTH];
    rob_entry_t       rob_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             err_q, err_d;
    logic [1:0]       wb_we_q;
    logic [4:0]       wb_rd0_q, wb_rd1_q;
    logic [WIDTH-1:0] wb_data0_q, wb_data1_q;
    logic             retire_pulse_q;

    wb_result_t br_res, mem_res;
    rob_entry_t head_e;
    logic       br_hit, mem_hit, collide, br_ok, mem_ok;
    logic       alloc_fire, retire;
    logic [1:0] res_we;

    assign br_res  = '{valid: br_valid, tag: br_tag, slot: br_slot, rd: br_rd, we: br_we, data: br_data};
    assign mem_res = '{valid: mem_valid, tag: mem_tag, slot: mem_slot, rd: mem_rd, we: mem_we, data: mem_data};

    assign alloc_ready = (count_q < DEPTH_C);
    assign alloc_tag   = tail_q;
    assign head_e      = rob_q[head_q];
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign retire      = head_e.valid && (&head_e.done) && !flush;

    // A result is legal only for an allocated entry, a masked slot, and a slot not yet completed
    assign br_hit  = br_res.valid && rob_q[br_res.tag].valid && rob_q[br_res.tag].mask[br_res.slot]
                     && !rob_q[br_res.tag].done[br_res.slot];
    assign mem_hit = mem_res.valid && rob_q[mem_res.tag].valid && rob_q[mem_res.tag].mask[mem_res.slot]
                     && !rob_q[mem_res.tag].done[mem_res.slot];
    assign collide = br_res.valid && mem_res.valid && (br_res.tag == mem_res.tag) && (br_res.slot == mem_res.slot);
    assign br_ok   = br_hit && !collide && !flush;
    assign mem_ok  = mem_hit && !collide && !flush;

    wb_conflict_resolve u_resolve (
        .mask_i (head_e.mask),
        .we_i   ({head_e.slot[1].we, head_e.slot[0].we}),
        .rd0_i  (head_e.slot[0].rd),
        .rd1_i  (head_e.slot[1].rd),
        .we_o   (res_we)
    );

    always_comb begin
        rob_d   = rob_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
        err_d   = err_q | (br_res.valid && !br_hit) | (mem_res.valid && !mem_hit) | collide;

        if (retire) begin
            rob_d[head_q] = '0;
            head_d        = head_q + TAG_W'(1);
        end
        if (alloc_fire) begin
            rob_d[tail_q].valid = 1'b1;
            rob_d[tail_q].mask  = alloc_mask;
            rob_d[tail_q].done  = ~alloc_mask;
            tail_d              = tail_q + TAG_W'(1);
        end
        if (br_ok) begin
            rob_d[br_res.tag].done[br_res.slot]      = 1'b1;
            rob_d[br_res.tag].slot[br_res.slot].rd   = br_res.rd;
            rob_d[br_res.tag].slot[br_res.slot].we   = br_res.we;
            rob_d[br_res.tag].slot[br_res.slot].data = br_res.data;
        end
        if (mem_ok) begin
            rob_d[mem_res.tag].done[mem_res.slot]      = 1'b1;
            rob_d[mem_res.tag].slot[mem_res.slot].rd   = mem_res.rd;
            rob_d[mem_res.tag].slot[mem_res.slot].we   = mem_res.we;
            rob_d[mem_res.tag].slot[mem_res.slot].data = mem_res.data;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) rob_d[i] = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            err_q          <= 1'b0;
            wb_we_q        <= '0;
            wb_rd0_q       <= '0;
            wb_rd1_q       <= '0;
            wb_data0_q     <= '0;
            wb_data1_q     <= '0;
            retire_pulse_q <= 1'b0;
        end else begin
            rob_q          <= rob_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            err_q          <= err_d;
            retire_pulse_q <= retire;
            wb_we_q        <= retire ? res_we : 2'b00;
            if (retire) begin
                wb_rd0_q   <= head_e.slot[0].rd;
                wb_rd1_q   <= head_e.slot[1].rd;
                wb_data0_q <= head_e.slot[0].data;
                wb_data1_q <= head_e.slot[1].data;
            end
        end
    end

    assign wb_we_0      = wb_we_q[0];
    assign wb_we_1      = wb_we_q[1];
    assign wb_rd_0      = wb_rd0_q;
    assign wb_rd_1      = wb_rd1_q;
    assign wb_data_0    = wb_data0_q;
    assign wb_data_1    = wb_data1_q;
    assign retire_pulse = retire_pulse_q;
    assign err          = err_q;

`ifdef RETIRE_COUNT_EN
    logic [63:0] retire_count_q;

    // Counts retired instructions, so flush intentionally leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count_q <= '0;
        end else if (retire) begin
            retire_count_q <= retire_count_q + 64'(popcount2(head_e.mask));
        end
    end

    assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_writeback_reorder_unit.sv
// Directed testbench for writeback_reorder_unit with hand-computed expectations.
module tb_writeback_reorder_unit;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic [1:0]  alloc_mask;
    logic        alloc_ready;
    logic [1:0]  alloc_tag;
    logic        br_valid;
    logic [1:0]  br_tag;
    logic        br_slot;
    logic [4:0]  br_rd;
    logic        br_we;
    logic [31:0] br_data;
    logic        mem_valid;
    logic [1:0]  mem_tag;
    logic        mem_slot;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic [31:0] mem_data;
    logic        flush;
    logic        wb_we_0, wb_we_1;
    logic [4:0]  wb_rd_0, wb_rd_1;
    logic [31:0] wb_data_0, wb_data_1;
    logic        retire_pulse;
    logic        err;
`ifdef RETIRE_COUNT_EN
    logic [63:0] retire_count;
`endif

    int n_total;
    int n_bad;

    writeback_reorder_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_mask   (alloc_mask),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .br_valid     (br_valid),
        .br_tag       (br_tag),
        .br_slot      (br_slot),
        .br_rd        (br_rd),
        .br_we        (br_we),
        .br_data      (br_data),
        .mem_valid    (mem_valid),
        .mem_tag      (mem_tag),
        .mem_slot     (mem_slot),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
        .mem_data     (mem_data),
        .flush        (flush),
        .wb_we_0      (wb_we_0),
        .wb_we_1      (wb_we_1),
        .wb_rd_0      (wb_rd_0),
        .wb_rd_1      (wb_rd_1),
        .wb_data_0    (wb_data_0),
        .wb_data_1    (wb_data_1),
        .retire_pulse (retire_pulse),
        .err          (err)
`ifdef RETIRE_COUNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        alloc_valid = 1'b0;
        br_valid    = 1'b0;
        mem_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    // One clock edge, then sample 1ns later and drop single-cycle strobes
    task automatic step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic do_alloc(input logic [1:0] m);
        alloc_valid = 1'b1;
        alloc_mask  = m;
        step();
    endtask

    task automatic drive_br(input logic [1:0] t, input logic s, input logic [4:0] rd, input logic we, input logic [31:0] d);
        br_valid = 1'b1; br_tag = t; br_slot = s; br_rd = rd; br_we = we; br_data = d;
    endtask

    task automatic drive_mem(input logic [1:0] t, input logic s, input logic [4:0] rd, input logic we, input logic [31:0] d);
        mem_valid = 1'b1; mem_tag = t; mem_slot = s; mem_rd = rd; mem_we = we; mem_data = d;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        alloc_mask = 2'b00;
        br_tag = '0; br_slot = 1'b0; br_rd = '0; br_we = 1'b0; br_data = '0;
        mem_tag = '0; mem_slot = 1'b0; mem_rd = '0; mem_we = 1'b0; mem_data = '0;
        clear_strobes();
        #3;
        chk("rst_ready", alloc_ready, 1);
        chk("rst_tag", alloc_tag, 0);
        chk("rst_we0", wb_we_0, 0);
        chk("rst_we1", wb_we_1, 0);
        chk("rst_pulse", retire_pulse, 0);
        chk("rst_err", err, 0);
        chk("rst_data0", wb_data_0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Basic two-slot bundle, results out of order across pipelines
        do_alloc(2'b11);
        chk("t1_tag", alloc_tag, 1);
        drive_br(2'd0, 1'b1, 5'd5, 1'b1, 32'hAA);
        step();
        chk("t1_err", err, 0);
        chk("t1_early", retire_pulse, 0);
        drive_mem(2'd0, 1'b0, 5'd6, 1'b1, 32'hBB);
        step();
        chk("t1_wait", retire_pulse, 0);
        step();
        chk("t1_pulse", retire_pulse, 1);
        chk("t1_we0", wb_we_0, 1);
        chk("t1_rd0", wb_rd_0, 6);
        chk("t1_d0", wb_data_0, 32'hBB);
        chk("t1_we1", wb_we_1, 1);
        chk("t1_rd1", wb_rd_1, 5);
        chk("t1_d1", wb_data_1, 32'hAA);

        // Same destination in both slots: younger wins
        do_alloc(2'b11);
        drive_br(2'd1, 1'b0, 5'd7, 1'b1, 32'h1);
        drive_mem(2'd1, 1'b1, 5'd7, 1'b1, 32'h2);
        step();
        step();
        chk("t2_pulse", retire_pulse, 1);
        chk("t2_we0", wb_we_0, 0);
        chk("t2_we1", wb_we_1, 1);
        chk("t2_rd1", wb_rd_1, 7);
        chk("t2_d1", wb_data_1, 32'h2);
        step();
        chk("t2_idle", retire_pulse, 0);

        // Flush with three bundles in flight, one of them about to retire
        do_alloc(2'b01);
        do_alloc(2'b01);
        do_alloc(2'b01);
        chk("t6_tag", alloc_tag, 1);
        drive_br(2'd2, 1'b0, 5'd3, 1'b1, 32'h33);
        step();
        flush = 1'b1;
        step();
        chk("t6_pulse", retire_pulse, 0);
        chk("t6_we0", wb_we_0, 0);
        chk("t6_ready", alloc_ready, 1);
        chk("t6_tag0", alloc_tag, 0);
        chk("t6_err", err, 0);
        step();
        step();
        chk("t6_quiet", retire_pulse, 0);

        // Fill the buffer, complete out of order
        do_alloc(2'b01);
        do_alloc(2'b01);
        do_alloc(2'b01);
        do_alloc(2'b01);
        chk("t3_full", alloc_ready, 0);
        chk("t3_wrap", alloc_tag, 0);
        drive_br(2'd1, 1'b0, 5'd9, 1'b1, 32'h11);
        step();
        step();
        chk("t3_hold", retire_pulse, 0);
        drive_mem(2'd0, 1'b0, 5'd8, 1'b1, 32'h10);
        step();
        chk("t3_wait", retire_pulse, 0);
        step();
        chk("t3_p0", retire_pulse, 1);
        chk("t3_we0a", wb_we_0, 1);
        chk("t3_rd0a", wb_rd_0, 8);
        chk("t3_d0a", wb_data_0, 32'h10);
        chk("t3_we1a", wb_we_1, 0);
        chk("t3_ready", alloc_ready, 1);
        step();
        chk("t3_p1", retire_pulse, 1);
        chk("t3_we0b", wb_we_0, 1);
        chk("t3_rd0b", wb_rd_0, 9);
        chk("t3_d0b", wb_data_0, 32'h11);
        step();
        chk("t3_stop", retire_pulse, 0);

        // rd=0 with we=1, and we=0: both retire without writing
        drive_br(2'd2, 1'b0, 5'd0, 1'b1, 32'h55);
        drive_mem(2'd3, 1'b0, 5'd4, 1'b0, 32'h66);
        step();
        step();
        chk("t4_p2", retire_pulse, 1);
        chk("t4_we0_rd0", wb_we_0, 0);
        chk("t4_d0", wb_data_0, 32'h55);
        step();
        chk("t4_p3", retire_pulse, 1);
        chk("t4_we0_nowe", wb_we_0, 0);
        chk("t4_rd0", wb_rd_0, 4);
        step();
        chk("t4_idle", retire_pulse, 0);
        chk("t4_err", err, 0);

        // Result to an unallocated tag: sticky error, state untouched
        drive_br(2'd3, 1'b0, 5'd1, 1'b1, 32'h99);
        step();
        chk("t5_err", err, 1);
        chk("t5_ready", alloc_ready, 1);
        chk("t5_tag", alloc_tag, 0);
        chk("t5_nopulse", retire_pulse, 0);
        step();
        flush = 1'b1;
        step();
        chk("t5_sticky", err, 1);
        do_alloc(2'b10);
        drive_mem(2'd0, 1'b1, 5'd12, 1'b1, 32'h77);
        step();
        step();
        chk("t5_pulse", retire_pulse, 1);
        chk("t5_we1", wb_we_1, 1);
        chk("t5_d1", wb_data_1, 32'h77);
        chk("t5_we0", wb_we_0, 0);

        // Asynchronous reset between edges drops outputs immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we1", wb_we_1, 0);
        chk("ar_pulse", retire_pulse, 0);
        chk("ar_err", err, 0);
        chk("ar_tag", alloc_tag, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
